wb_unit: RTL
============

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width in bits.
REQ-002 SHALL have parameter NUM_SRC, default 4, meaning number of memory read sources.
REQ-003 SHALL have parameter SLOW_SRC, default NUM_SRC-1, meaning index of the variable-latency source.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning maximum slow-source wait in cycles.
REQ-005 Ports; one clock; reset is synchronous and active-high:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  MEM-stage instruction valid
  in_ready  out  1  wb_unit can accept this cycle
  in_inst  in  32  instruction word
  in_alu  in  XLEN  ALU result / load address
  in_pc4  in  XLEN  PC+4
  in_src_sel  in  clog2(NUM_SRC)  load source index
  src_dout  in  NUM_SRC*XLEN  fast-source read data, valid in accept cycle
  slow_req  out  1  one-cycle read request to slow source
  slow_valid  in  1  slow-source data valid
  slow_data  in  XLEN  slow-source read data
  rf_wen  out  1  register-file write enable
  rf_waddr  out  5  destination register
  rf_wdata  out  XLEN  write data
  misalign  out  1  one-cycle pulse, misaligned load dropped
  timeout_err  out  1  one-cycle pulse, slow-source timeout

Function
REQ-006 Accept occurs when in_valid && in_ready.
REQ-007 Write select by opcode: JAL/JALR -> in_pc4; LOAD -> aligned load data; OP/OP-IMM/LUI/AUIPC -> in_alu; all others -> no write.
REQ-008 rf_wen SHALL be 0 when rd == 0.
REQ-009 Load alignment by funct3 and in_alu[1:0]: LB/LBU byte lane, sign/zero extend; LH/LHU halfword lane, sign/zero extend; LW full word.
REQ-010 LH/LHU with addr[0]=1 or LW with addr[1:0]!=0 SHALL suppress the write and pulse misalign for one cycle.
REQ-011 Fast path: accepted non-slow instruction SHALL produce rf_wen/rf_waddr/rf_wdata registered, exactly 1 cycle after accept.
REQ-012 Outputs rf_wen, misalign, timeout_err SHALL be single-cycle pulses, 0 otherwise.
REQ-013 FSM states IDLE, WAIT. in_ready = 1 in IDLE, 0 in WAIT.
REQ-014 IDLE -> WAIT on accept of a LOAD with in_src_sel == SLOW_SRC; slow_req pulses in the accept cycle; inst and address captured.
REQ-015 WAIT -> IDLE on slow_valid; slow_data aligned per REQ-009 and written 1 cycle later.
REQ-016 slow_valid in IDLE SHALL be ignored.
REQ-017 Misaligned slow load SHALL not enter WAIT and SHALL not assert slow_req.
REQ-018 in_src_sel >= NUM_SRC SHALL read as zero data.

Reset
REQ-019 rst SHALL force state IDLE, wait counter 0, all outputs 0, in_ready 1 on the following cycle.
REQ-020 rst during WAIT SHALL abandon the pending load with no write; a later slow_valid is ignored.

Configuration
REQ-021 Macro WB_TIMEOUT_EN defined: wait counter runs in WAIT; on reaching TIMEOUT cycles without slow_valid, the unit writes 0 to rd, pulses timeout_err, returns to IDLE; slow_valid in the same cycle as expiry wins.
REQ-022 WB_TIMEOUT_EN undefined: no counter; WAIT persists until slow_valid; timeout_err tied 0.

Structure
REQ-023 Package wb_pkg SHALL hold opcode constants, funct3 load codes, and the FSM state typedef.
REQ-024 Sub-module load_align SHALL implement REQ-009/REQ-010 combinationally (data, funct3, addr[1:0] -> aligned data, misalign).

Verification
REQ-025 ADD x5 with in_alu=0x1234 -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x00001234.
REQ-026 LB x6, addr=0x...3, fast src data 0x80FF_FF7F -> rf_wdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-027 LH addr[0]=1 -> misalign pulse, rf_wen=0.
REQ-028 LW slow source, slow_valid after 5 cycles with 0xDEADBEEF -> in_ready low 5 cycles, rf_wdata=0xDEADBEEF 1 cycle after slow_valid.
REQ-029 WB_TIMEOUT_EN, TIMEOUT=16, no slow_valid -> after 16 cycles rf_wen=1, rf_wdata=0, timeout_err=1, in_ready=1.
REQ-030 rst in WAIT, then slow_valid -> no rf_wen; JAL x0 -> no rf_wen.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared decode constants, load funct3 codes and FSM state encoding for the
// write-back unit.
package wb_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  typedef enum logic [1:0] {
    WSEL_NONE,
    WSEL_PC4,
    WSEL_LOAD,
    WSEL_ALU
  } wsel_t;

  function automatic wsel_t decode_wsel(input logic [6:0] opcode);
    wsel_t sel;
    case (opcode)
      OPC_JAL, OPC_JALR:                      sel = WSEL_PC4;
      OPC_LOAD:                               sel = WSEL_LOAD;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: sel = WSEL_ALU;
      default:                                sel = WSEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction with sign/zero extension and
// misalignment detection for halfword and word loads.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  output logic [XLEN-1:0] aligned,
  output logic            misalign
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = data[7:0];
      2'd1:    byte_lane = data[15:8];
      2'd2:    byte_lane = data[23:16];
      default: byte_lane = data[31:24];
    endcase
    half_lane = addr[1] ? data[31:16] : data[15:0];
  end

  // Unlisted funct3 codes pass the word through untouched and never fault.
  always_comb begin
    aligned  = data;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  aligned = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      F3_LBU: aligned = {{(XLEN-8){1'b0}}, byte_lane};
      F3_LH: begin
        aligned  = {{(XLEN-16){half_lane[15]}}, half_lane};
        misalign = addr[0];
      end
      F3_LHU: begin
        aligned  = {{(XLEN-16){1'b0}}, half_lane};
        misalign = addr[0];
      end
      F3_LW:   misalign = |addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: registered RF write from ALU/PC+4/load data, with a
// one-deep wait for a variable-latency load source. WB_TIMEOUT_EN adds a wait limit.
module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_SRC  = 4,
  parameter int SLOW_SRC = NUM_SRC - 1,
  parameter int TIMEOUT  = 16,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_alu,
  input  logic [XLEN-1:0]         in_pc4,
  input  logic [SEL_W-1:0]        in_src_sel,
  input  logic [NUM_SRC*XLEN-1:0] src_dout,
  output logic                    slow_req,
  input  logic                    slow_valid,
  input  logic [XLEN-1:0]         slow_data,
  output logic                    rf_wen,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  output logic                    misalign,
  output logic                    timeout_err
);

  state_t          state_reg, state_next;
  logic [4:0]      cap_rd_reg;
  logic [2:0]      cap_f3_reg;
  logic [1:0]      cap_addr_reg;
  logic            rf_wen_reg, rf_wen_next;
  logic [4:0]      rf_waddr_reg, rf_waddr_next;
  logic [XLEN-1:0] rf_wdata_reg, rf_wdata_next;
  logic            misalign_reg, misalign_next;
  logic            tmo_next;
  logic            expire;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  wsel_t           wsel;
  logic            accept;
  logic [31:0]     sel_ext;
  logic [XLEN-1:0] fast_data, fast_aligned, slow_aligned, fast_wdata;
  logic            fast_mis, is_slow, go_wait;
  logic            unused_slow_mis;
  logic            unused_bits;

  assign opcode   = in_inst[6:0];
  assign rd       = in_inst[11:7];
  assign funct3   = in_inst[14:12];
  assign wsel     = decode_wsel(opcode);
  assign in_ready = (state_reg == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign sel_ext  = 32'(in_src_sel);

  assign unused_bits = ^in_inst[31:15];

  // Out-of-range selectors fall through to zero data.
  always_comb begin
    fast_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_ext == 32'(i)) fast_data = src_dout[i*XLEN +: XLEN];
    end
  end

  load_align #(.XLEN(XLEN)) u_fast_align (
    .data     (fast_data),
    .funct3   (funct3),
    .addr     (in_alu[1:0]),
    .aligned  (fast_aligned),
    .misalign (fast_mis)
  );

  load_align #(.XLEN(XLEN)) u_slow_align (
    .data     (slow_data),
    .funct3   (cap_f3_reg),
    .addr     (cap_addr_reg),
    .aligned  (slow_aligned),
    .misalign (unused_slow_mis)
  );

  assign is_slow  = (wsel == WSEL_LOAD) && (sel_ext == 32'(SLOW_SRC));
  // A misaligned slow load is dropped on the spot and never bothers the source.
  assign go_wait  = accept && is_slow && !fast_mis;
  assign slow_req = go_wait && !rst;

  always_comb begin
    case (wsel)
      WSEL_PC4:  fast_wdata = in_pc4;
      WSEL_LOAD: fast_wdata = fast_aligned;
      WSEL_ALU:  fast_wdata = in_alu;
      default:   fast_wdata = '0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    rf_wen_next   = 1'b0;
    rf_waddr_next = '0;
    rf_wdata_next = '0;
    misalign_next = 1'b0;
    tmo_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (go_wait) begin
          state_next = ST_WAIT;
        end else if (accept) begin
          misalign_next = (wsel == WSEL_LOAD) && fast_mis;
          if ((wsel != WSEL_NONE) && !misalign_next && (rd != 5'd0)) begin
            rf_wen_next   = 1'b1;
            rf_waddr_next = rd;
            rf_wdata_next = fast_wdata;
          end
        end
      end
      ST_WAIT: begin
        // Data arriving in the expiry cycle takes precedence over the timeout.
        if (slow_valid) begin
          state_next    = ST_IDLE;
          rf_wen_next   = (cap_rd_reg != 5'd0);
          rf_waddr_next = cap_rd_reg;
          rf_wdata_next = slow_aligned;
        end else if (expire) begin
          state_next    = ST_IDLE;
          rf_wen_next   = (cap_rd_reg != 5'd0);
          rf_waddr_next = cap_rd_reg;
          tmo_next      = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cap_rd_reg   <= '0;
      cap_f3_reg   <= '0;
      cap_addr_reg <= '0;
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rf_wen_reg   <= rf_wen_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      misalign_reg <= misalign_next;
      if (go_wait) begin
        cap_rd_reg   <= rd;
        cap_f3_reg   <= funct3;
        cap_addr_reg <= in_alu[1:0];
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             timeout_reg;

  // Counter holds the number of completed wait cycles; it expires on the TIMEOUT-th.
  assign expire = (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= tmo_next;
      if ((state_reg == ST_WAIT) && (state_next == ST_WAIT)) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end
    end
  end

  assign timeout_err = timeout_reg;
`else
  logic unused_tmo;
  assign expire      = 1'b0;
  assign unused_tmo  = tmo_next;
  assign timeout_err = 1'b0;
`endif

  assign rf_wen   = rf_wen_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign misalign = misalign_reg;

endmodule
